// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arbiter
// Purpose  : Round-robin arbiter and sequencer in front of a read-first
//            dual-port RAM. Each cycle it grants up to two single-word
//            requests, one per RAM port, and never pairs two requests to the
//            same address when either of them is a write. Every granted
//            request (read or write) returns the RAM word to its requester
//            exactly two cycles after the grant.
// Ports    : clk, resetn            - clock, async active-low reset
//            req_valid/we/addr/wdata - packed per-requester request fields
//            req_grant               - combinational accept strobes
//            rsp_valid/rsp_rdata     - registered per-requester responses
//            ram_we*/addr*/data*     - combinational RAM port drive
//            ram_out1/ram_out2       - registered RAM read data
//            conflict_cnt            - saturating hazard-deferral count
// Revision : 1.0 - initial release
// ============================================================================
module dpram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic                           ram_we1,
  output logic                           ram_we2,
  output logic [ADDR_WIDTH-1:0]          ram_addr1,
  output logic [ADDR_WIDTH-1:0]          ram_addr2,
  output logic [DATA_WIDTH-1:0]          ram_data1,
  output logic [DATA_WIDTH-1:0]          ram_data2,
  input  logic [DATA_WIDTH-1:0]          ram_out1,
  input  logic [DATA_WIDTH-1:0]          ram_out2,
  output logic [15:0]                    conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so ptr + offset can be formed before the modulo wrap.
  localparam int IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] N_W = IDX_W'(NUM_REQ);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = (v >= N_W) ? (v - N_W) : v;
    return r[PTR_W-1:0];
  endfunction

  // Unpacked views of the packed request buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // State
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [15:0]                 conflict_cnt_q, conflict_cnt_d;
  logic                        s1_v1_q, s1_v1_d, s1_v2_q, s1_v2_d;
  logic [PTR_W-1:0]            s1_id1_q, s1_id1_d, s1_id2_q, s1_id2_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Scan results
  logic                        a_found, b_found;
  logic [PTR_W-1:0]            a_idx, b_idx, scan_idx, last_idx;
  logic [IDX_W-1:0]            skip_cnt;
  logic [16:0]                 cnt_sum;

  // Round-robin scan: A is the first valid requester from ptr; B is the
  // first later one without a hazard against A. Hazard-skipped requesters
  // seen before B (or before the scan ends) are counted.
  always_comb begin
    a_found  = 1'b0;
    a_idx    = '0;
    b_found  = 1'b0;
    b_idx    = '0;
    skip_cnt = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = wrap_idx({1'b0, ptr_q} + IDX_W'(k));
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          if ((addr_arr[scan_idx] == addr_arr[a_idx]) &&
              (req_we[scan_idx] || req_we[a_idx])) begin
            skip_cnt = skip_cnt + IDX_W'(1);
          end else begin
            b_found = 1'b1;
            b_idx   = scan_idx;
          end
        end
      end
    end
  end

  // Grants and RAM port drive. Grants and write enables are held low while
  // reset is asserted so nothing reaches the RAM during reset.
  always_comb begin
    req_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resetn && ((a_found && (a_idx == PTR_W'(i))) ||
                     (b_found && (b_idx == PTR_W'(i))))) begin
        req_grant[i] = 1'b1;
      end
    end
    ram_we1   = resetn && a_found && req_we[a_idx];
    ram_addr1 = a_found ? addr_arr[a_idx]  : '0;
    ram_data1 = a_found ? wdata_arr[a_idx] : '0;
    ram_we2   = resetn && b_found && req_we[b_idx];
    ram_addr2 = b_found ? addr_arr[b_idx]  : '0;
    ram_data2 = b_found ? wdata_arr[b_idx] : '0;
  end

  // Next-state: pointer, counter, two-stage response pipeline.
  always_comb begin
    last_idx = b_found ? b_idx : a_idx;
    ptr_d    = ptr_q;
    if (a_found) begin
      ptr_d = wrap_idx({1'b0, last_idx} + IDX_W'(1));
    end

    cnt_sum        = {1'b0, conflict_cnt_q} + 17'(skip_cnt);
    conflict_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    s1_v1_d  = a_found;
    s1_id1_d = a_idx;
    s1_v2_d  = b_found;
    s1_id2_d = b_idx;

    // Stage 2: route the RAM outputs back to the requesters recorded in
    // stage 1; everyone else keeps their last response data.
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s1_v1_q && (s1_id1_q == PTR_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_out1;
      end else if (s1_v2_q && (s1_id2_q == PTR_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_out2;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q          <= '0;
      conflict_cnt_q <= '0;
      s1_v1_q        <= 1'b0;
      s1_id1_q       <= '0;
      s1_v2_q        <= 1'b0;
      s1_id2_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
    end else begin
      ptr_q          <= ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      s1_v1_q        <= s1_v1_d;
      s1_id1_q       <= s1_id1_d;
      s1_v2_q        <= s1_v2_d;
      s1_id2_q       <= s1_id2_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_arbiter
// Purpose  : Randomized self-checking bench for dpram_arbiter with a
//            behavioural read-first dual-port RAM and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NCYC   = 600;
  localparam int RST_AT = 300;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid, req_we, req_grant, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic            ram_we1, ram_we2;
  logic [AW-1:0]   ram_addr1, ram_addr2;
  logic [DW-1:0]   ram_data1, ram_data2, ram_out1, ram_out2;
  logic [15:0]     conflict_cnt;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we1(ram_we1), .ram_we2(ram_we2),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2),
    .ram_out1(ram_out1), .ram_out2(ram_out2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural read-first dual-port RAM
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_data1;
    if (ram_we2) mem[ram_addr2] <= ram_data2;
    ram_out1 <= mem[ram_addr1];
    ram_out2 <= mem[ram_addr2];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected responses in issue order
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // Monitor
  logic [DW-1:0] last_rd [N];
  logic [N-1:0]  mon_ev;
  logic [DW-1:0] mon_ed [N];
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) last_rd[i] = '0;
    end else begin
      mon_ev = '0;
      for (int i = 0; i < N; i++) mon_ed[i] = '0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        mon_ev[mon_e.id] = 1'b1;
        mon_ed[mon_e.id] = mon_e.data;
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(mon_ev));
      for (int i = 0; i < N; i++) begin
        if (mon_ev[i]) begin
          chk("rsp_rdata", 64'(rsp_rdata[i*DW +: DW]), 64'(mon_ed[i]));
          last_rd[i] = mon_ed[i];
        end else begin
          chk("rsp_hold", 64'(rsp_rdata[i*DW +: DW]), 64'(last_rd[i]));
        end
      end
    end
  end

  // Requester state and reference model
  logic          rv  [N];
  logic          rwe [N];
  logic [AW-1:0] ra  [N];
  logic [DW-1:0] rd  [N];
  logic [DW-1:0] shadow [256];
  int            mptr, mcnt;

  task automatic new_req(input int i);
    rv[i]  = ($urandom_range(0, 3) != 0);
    rwe[i] = ($urandom_range(0, 2) == 0);
    ra[i]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    rd[i]  = $urandom;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rv[i];
      req_we[i]             = rwe[i];
      req_addr[i*AW +: AW]  = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
    end
  endtask

  initial begin
    logic [N-1:0]  gexp;
    logic [DW-1:0] da, db;
    int            order[$];
    int            a, b, skips, j;
    bit            rel_chk;

    for (int i = 0; i < 256; i++) begin
      mem[i]   <= '0;
      shadow[i] = '0;
    end
    resetn  = 1'b0;
    mptr    = 0;
    mcnt    = 0;
    rel_chk = 1'b0;
    for (int i = 0; i < N; i++) begin
      new_req(i);
      rv[i] = 1'b1;
    end
    pack();

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      gexp = '0;
      if (!resetn) begin
        chk("rst_grant", 64'(req_grant), 64'(0));
        chk("rst_we", 64'({ram_we1, ram_we2}), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
        sb.delete();
        mptr = 0;
        mcnt = 0;
      end else begin
        chk("conflict_cnt", 64'(conflict_cnt), 64'(mcnt));
        // Valid requesters in round-robin order from mptr
        order.delete();
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (rv[j]) order.push_back(j);
        end
        a = -1; b = -1; skips = 0;
        if (order.size() > 0) begin
          a = order[0];
          for (int m = 1; m < order.size(); m++) begin
            j = order[m];
            if (ra[j] == ra[a] && (rwe[j] || rwe[a])) skips++;
            else begin
              b = j;
              break;
            end
          end
        end
        if (a >= 0) gexp[a] = 1'b1;
        if (b >= 0) gexp[b] = 1'b1;
        chk("req_grant", 64'(req_grant), 64'(gexp));
        chk("ram_port1", 64'({ram_we1, ram_addr1}), (a >= 0) ? 64'({rwe[a], ra[a]}) : 64'(0));
        chk("ram_port2", 64'({ram_we2, ram_addr2}), (b >= 0) ? 64'({rwe[b], ra[b]}) : 64'(0));
        if (rel_chk) chk("release_prio_req0", 64'(req_grant[0]), 64'(1));
        // Read-first: each response carries the word's prior contents
        da = (a >= 0) ? shadow[ra[a]] : '0;
        db = (b >= 0) ? shadow[ra[b]] : '0;
        if (a >= 0) begin
          sb.push_back('{due: cyc + 2, id: a, data: da});
          if (rwe[a]) shadow[ra[a]] = rd[a];
        end
        if (b >= 0) begin
          sb.push_back('{due: cyc + 2, id: b, data: db});
          if (rwe[b]) shadow[ra[b]] = rd[b];
        end
        mcnt = (mcnt + skips > 65535) ? 65535 : mcnt + skips;
        if (a >= 0) mptr = (((b >= 0) ? b : a) + 1) % N;
      end
      rel_chk = 1'b0;

      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (c >= NCYC - 6) begin
          if (gexp[i]) rv[i] = 1'b0;
        end else if (gexp[i] || !rv[i]) begin
          new_req(i);
        end
      end
      if (c == RST_AT) begin
        resetn = 1'b0;
        for (int i = 0; i < N; i++) rv[i] = 1'b1;
      end else if (!resetn) begin
        resetn  = 1'b1;
        rel_chk = 1'b1;
      end
      pack();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpram_arbiter.md
# dpram_arbiter

Round-robin arbiter and sequencer placed in front of `dual_port_ram`. It accepts single-word read/write requests from NUM_REQ independent requesters and schedules up to two per cycle onto the RAM's two ports, blocking same-address write hazards. It returns read data, or a write acknowledge, to the originating requester with a fixed two-cycle latency. It is the sharing point that lets several processing elements use one block RAM.

## Interface
- DATA_WIDTH, 32, RAM word width; must match the RAM instance.
- ADDR_WIDTH, 8, RAM address width; must match the RAM instance.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- clk  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, packed the same way.
- req_grant  out  NUM_REQ  combinational; the request is accepted in a cycle where valid & grant.
- rsp_valid  out  NUM_REQ  registered one-cycle response pulse.
- rsp_rdata  out  NUM_REQ*DATA_WIDTH  registered response data, packed.
- ram_we1, ram_we2  out  1  combinational RAM write enables.
- ram_addr1, ram_addr2  out  ADDR_WIDTH  combinational RAM addresses.
- ram_data1, ram_data2  out  DATA_WIDTH  combinational RAM write data.
- ram_out1, ram_out2  in  DATA_WIDTH  RAM registered read data (read-first).
- conflict_cnt  out  16  saturating count of hazard deferrals.

## Operation
- **Round-robin pointer.** ptr is a clog2(NUM_REQ)-bit register, reset to 0. Candidates are scanned in order ptr, ptr+1, … (mod NUM_REQ).
- **Port 1 winner (A).** A is the first valid requester in scan order. It drives port 1: ram_we1 = req_we[A], ram_addr1/ram_data1 = requester A's fields.
- **Port 2 winner (B).** B is the next valid requester after A in scan order that has no hazard with A. B drives port 2.
- **Hazard.** Same address, and at least one of the two requests is a write. Two reads of the same address are not a hazard and are both granted.
- **Hazard skip.** Every valid requester skipped for a hazard, scanning up to and including B (or to the end of the scan if there is no B), adds 1 to conflict_cnt. The counter saturates at 16'hFFFF.
- **Grants.** req_grant has at most two bits set: A and B.
- **Idle outputs.** With no winner on a port, that port's we = 0, addr = 0 and data = 0.
- **Pointer update.** ptr <= (last granted index in scan order) + 1, mod NUM_REQ. If nothing is granted, ptr is unchanged.
- **Pipeline.** stage 1 holds {valid, requester id} per port, captured at the grant edge. Stage 2 captures ram_out1/ram_out2 into rsp_rdata of the recorded requester and pulses its rsp_valid.
- **Write responses.** A write also produces a response. Its rsp_rdata is the word's prior contents (read-first RAM).
- **Unaffected outputs.** Requesters with no response keep their rsp_rdata value; their rsp_valid is 0.
- **Requester contract.** A requester holds req_* stable until granted. After a grant it may present a new request the next cycle, so back-to-back requests give one response per cycle.

## Timing
- Request granted in cycle T → RAM samples it at the edge ending T → ram_out is valid in T+1 → rsp_valid/rsp_rdata are high in T+2. Latency is exactly 2 cycles, with no bubbles.
- Throughput: 2 requests/cycle; 1/cycle per requester at most.
- Reset (resetn = 0, asynchronous):
  - ptr = 0, both stage-1 valids = 0, rsp_valid = 0, rsp_rdata = 0, conflict_cnt = 0.
  - req_grant and ram_we1/2 are forced to 0 while reset is asserted.
- Reset mid-operation: in-flight responses are discarded (no rsp_valid after release). RAM contents are not touched.
- First cycle after release: normal arbitration starting at requester 0.
- Simultaneous requests to a single requester's own stream: not possible (one request per requester).

## Test plan
- **Single read.** Preload addr 0x10 = 0xDEADBEEF. Requester 2 reads 0x10 in cycle T → req_grant = 4'b0100 in T; rsp_valid[2] = 1 with rsp_rdata[2] = 0xDEADBEEF in T+2 only.
- **Dual grant and pointer advance.** All four requesters read distinct addresses continuously from ptr = 0 → grants 0011, 1100, 0011, …; each rsp arrives 2 cycles after its grant.
- **Write hazard.** Requester 0 writes 0x20 = 0x1234 while requester 1 reads 0x20 and requester 2 reads 0x30 (ptr = 0) → grant = 0101, conflict_cnt = 1. Requester 1 is granted in a later cycle and reads 0x1234.
- **Same-address reads.** Requesters 0 and 1 both read 0x40 → grant = 0011, conflict_cnt unchanged, identical rsp_rdata.
- **Write ack.** Requester 3 writes 0x55 = 0xA5A5A5A5 over old value 0x0 → rsp_valid[3] in T+2 with rsp_rdata[3] = 0x0. A following read of 0x55 returns 0xA5A5A5A5.
- **Reset mid-flight.** Grant in T, then assert resetn = 0 in T+1 → no rsp_valid in T+2; all outputs and conflict_cnt = 0. After release, requester 0 has priority.
